// File: rtl/spi_counter_pkg.sv
// Shared types and constants for the SPI counter receiver.
// Range checking is enabled by defining SPI_COUNTER_RX_RANGE_CHECK_EN.
package spi_counter_pkg;

  localparam int FRAME_BITS = 16;
  localparam int BYTE_BITS  = 8;
  localparam int COUNT_BITS = FRAME_BITS - 2;
  localparam logic [COUNT_BITS-1:0] COUNT_MAX = COUNT_BITS'(9999);

  typedef enum logic [2:0] {
    IDLE,
    RX_HIGH,
    RX_LOW,
    WAIT_END,
    UPDATE
  } state_t;

  function automatic logic value_in_range(input logic [BYTE_BITS-1:0] high,
                                          input logic [BYTE_BITS-1:0] low);
    return (high[7:6] == 2'b00) && ({high[5:0], low} <= COUNT_MAX);
  endfunction

endpackage

// File: rtl/spi_slave_rx_byte.sv
// SPI mode-0 front end: input synchronizers, sclk/ss_n edge detection and an
// MSB-first byte shifter that pulses byte_done after every eighth bit.
module spi_slave_rx_byte
  import spi_counter_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 sclk,
  input  logic                 mosi,
  input  logic                 ss_n,
  input  logic                 clear,
  output logic                 sclk_rise,
  output logic                 ss_fall,
  output logic                 ss_rise,
  output logic [BYTE_BITS-1:0] byte_data,
  output logic                 byte_done
);

  localparam int CNT_W = $clog2(BYTE_BITS);
  localparam logic [2:0] SYNC_RST = 3'b100;  // {ss_n, sclk, mosi}

  logic [SYNC_STAGES-1:0][2:0] stage_reg, stage_next;
  logic [SYNC_STAGES-1:0]      fill_reg, fill_next;
  logic                        ss_sync, sclk_sync, mosi_sync;
  logic                        sclk_prev_reg, ss_prev_reg, armed_reg;
  logic [BYTE_BITS-1:0]        shift_reg;
  logic [CNT_W-1:0]            bit_cnt_reg;
  logic                        byte_done_reg;

  genvar gi;
  generate
    for (gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
      if (gi == 0) begin : g_head
        assign stage_next[gi] = {ss_n, sclk, mosi};
        assign fill_next[gi]  = 1'b1;
      end else begin : g_tail
        assign stage_next[gi] = stage_reg[gi-1];
        assign fill_next[gi]  = fill_reg[gi-1];
      end
    end
  endgenerate

  assign {ss_sync, sclk_sync, mosi_sync} = stage_reg[SYNC_STAGES-1];

  // A falling ss_n only counts once a genuine high level has been seen after
  // reset, so releasing reset in the middle of a frame cannot start one.
  assign sclk_rise = sclk_sync & ~sclk_prev_reg;
  assign ss_fall   = armed_reg & ss_prev_reg & ~ss_sync;
  assign ss_rise   = ~ss_prev_reg & ss_sync;
  assign byte_data = shift_reg;
  assign byte_done = byte_done_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stage_reg     <= {SYNC_STAGES{SYNC_RST}};
      fill_reg      <= '0;
      sclk_prev_reg <= 1'b0;
      ss_prev_reg   <= 1'b1;
      armed_reg     <= 1'b0;
      shift_reg     <= '0;
      bit_cnt_reg   <= '0;
      byte_done_reg <= 1'b0;
    end else begin
      stage_reg     <= stage_next;
      fill_reg      <= fill_next;
      sclk_prev_reg <= sclk_sync;
      ss_prev_reg   <= ss_sync;
      byte_done_reg <= 1'b0;
      if (fill_reg[SYNC_STAGES-1] && ss_sync) begin
        armed_reg <= 1'b1;
      end
      if (clear) begin
        shift_reg   <= '0;
        bit_cnt_reg <= '0;
      end else if (sclk_rise && !ss_sync) begin
        shift_reg     <= {shift_reg[BYTE_BITS-2:0], mosi_sync};
        bit_cnt_reg   <= bit_cnt_reg + 1'b1;
        byte_done_reg <= (bit_cnt_reg == CNT_W'(BYTE_BITS - 1));
      end
    end
  end

endmodule

// File: rtl/spi_counter_rx.sv
// Receives 16-bit SPI frames and publishes {high[5:0], low} as a counter value.
// Define SPI_COUNTER_RX_RANGE_CHECK_EN to reject values above COUNT_MAX.
module spi_counter_rx
  import spi_counter_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  sclk,
  input  logic                  mosi,
  input  logic                  ss_n,
  output logic [COUNT_BITS-1:0] counter,
  output logic                  counter_valid,
  output logic                  frame_err
);

  state_t                state_reg, state_next;
  logic [BYTE_BITS-1:0]  high_reg, high_next, low_reg, low_next;
  logic                  overlong_reg, overlong_next;
  logic [COUNT_BITS-1:0] counter_reg, counter_next;
  logic                  counter_valid_reg, counter_valid_next;
  logic                  frame_err_reg, frame_err_next;
  logic                  clear, frame_ok;
  logic                  sclk_rise, ss_fall, ss_rise, byte_done;
  logic [BYTE_BITS-1:0]  byte_data;

  spi_slave_rx_byte #(.SYNC_STAGES(SYNC_STAGES)) u_rx_byte (
    .clk       (clk),
    .reset     (reset),
    .sclk      (sclk),
    .mosi      (mosi),
    .ss_n      (ss_n),
    .clear     (clear),
    .sclk_rise (sclk_rise),
    .ss_fall   (ss_fall),
    .ss_rise   (ss_rise),
    .byte_data (byte_data),
    .byte_done (byte_done)
  );

`ifdef SPI_COUNTER_RX_RANGE_CHECK_EN
  assign frame_ok = value_in_range(high_reg, low_reg);
`else
  logic [1:0] unused_high_bits;
  assign unused_high_bits = high_reg[7:6];
  assign frame_ok = 1'b1;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:     if (ss_fall) state_next = RX_HIGH;
      RX_HIGH:  if (ss_rise) state_next = IDLE;
                else if (byte_done) state_next = RX_LOW;
      RX_LOW:   if (ss_rise) state_next = IDLE;
                else if (byte_done) state_next = WAIT_END;
      WAIT_END: if (ss_rise) state_next = UPDATE;
      UPDATE:   state_next = IDLE;
      default:  state_next = IDLE;
    endcase
  end

  always_comb begin
    clear              = 1'b0;
    high_next          = high_reg;
    low_next           = low_reg;
    overlong_next      = overlong_reg;
    counter_next       = counter_reg;
    counter_valid_next = 1'b0;
    frame_err_next     = 1'b0;
    case (state_reg)
      IDLE: if (ss_fall) begin
        clear         = 1'b1;
        high_next     = '0;
        low_next      = '0;
        overlong_next = 1'b0;
      end
      RX_HIGH: if (ss_rise) frame_err_next = 1'b1;
               else if (byte_done) high_next = byte_data;
      RX_LOW:  if (ss_rise) frame_err_next = 1'b1;
               else if (byte_done) low_next = byte_data;
      // Any clock after the 16th bit poisons the frame; it is judged at UPDATE.
      WAIT_END: if (sclk_rise) overlong_next = 1'b1;
      UPDATE: if (overlong_reg || !frame_ok) begin
        frame_err_next = 1'b1;
      end else begin
        counter_next       = {high_reg[5:0], low_reg};
        counter_valid_next = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      high_reg          <= '0;
      low_reg           <= '0;
      overlong_reg      <= 1'b0;
      counter_reg       <= '0;
      counter_valid_reg <= 1'b0;
      frame_err_reg     <= 1'b0;
    end else begin
      high_reg          <= high_next;
      low_reg           <= low_next;
      overlong_reg      <= overlong_next;
      counter_reg       <= counter_next;
      counter_valid_reg <= counter_valid_next;
      frame_err_reg     <= frame_err_next;
    end
  end

  assign counter       = counter_reg;
  assign counter_valid = counter_valid_reg;
  assign frame_err     = frame_err_reg;

endmodule

// File: tb/tb_spi_counter_rx.sv
// Self-checking bench for spi_counter_rx: directed frame table, a reset
// mid-frame sequence, and random frames checked against a frame-level model.
module tb_spi_counter_rx;

  localparam int SYNC = 2;
  localparam int HALF = 5;
`ifdef SPI_COUNTER_RX_RANGE_CHECK_EN
  localparam bit RANGE_EN = 1'b1;
`else
  localparam bit RANGE_EN = 1'b0;
`endif

  typedef struct {
    logic [31:0] data;
    int          nbits;
    logic        exp_valid;
    logic [13:0] exp_counter;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset, sclk, mosi, ss_n;
  logic [13:0] counter;
  logic        counter_valid, frame_err;

  int          n_checks = 0;
  int          n_errors = 0;
  int          n_valid  = 0;
  int          n_err    = 0;
  int          n_both   = 0;
  logic [13:0] model_counter;
  vec_t        vecs [9];

  spi_counter_rx #(.SYNC_STAGES(SYNC)) dut (
    .clk           (clk),
    .reset         (reset),
    .sclk          (sclk),
    .mosi          (mosi),
    .ss_n          (ss_n),
    .counter       (counter),
    .counter_valid (counter_valid),
    .frame_err     (frame_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (counter_valid) n_valid++;
    if (frame_err) n_err++;
    if (counter_valid && frame_err) n_both++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  task automatic clk_wait(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bits(input logic [31:0] data, input int nbits);
    for (int i = nbits - 1; i >= 0; i--) begin
      mosi = data[i];
      clk_wait(HALF);
      sclk = 1'b1;
      clk_wait(HALF);
      sclk = 1'b0;
    end
  endtask

  // Frame-level reference: exactly 16 bits, value from the low 14 bits,
  // optionally restricted to high[7:6] == 0 and value <= 9999.
  function automatic void model_frame(input logic [31:0] data, input int nbits,
                                      output logic exp_valid, output logic [13:0] exp_counter);
    int hi, lo, value;
    hi = int'(data[15:8]);
    lo = int'(data[7:0]);
    value = (hi % 64) * 256 + lo;
    exp_valid = (nbits == 16) && (!RANGE_EN || (hi < 64 && value <= 9999));
    exp_counter = exp_valid ? 14'(value) : model_counter;
  endfunction

  task automatic run_frame(input logic [31:0] data, input int nbits,
                           input logic exp_valid, input logic [13:0] exp_counter);
    int v0, e0, b0;
    v0 = n_valid;
    e0 = n_err;
    b0 = n_both;
    ss_n = 1'b0;
    clk_wait(HALF);
    send_bits(data, nbits);
    clk_wait(HALF);
    ss_n = 1'b1;
    clk_wait(SYNC + 2);
    check("counter_latency", 32'(counter), 32'(exp_counter));
    clk_wait(8);
    check("valid_pulses", 32'(n_valid - v0), 32'(exp_valid));
    check("err_pulses", 32'(n_err - e0), 32'(!exp_valid));
    check("pulse_overlap", 32'(n_both - b0), 32'd0);
    $display("frame data=0x%0h bits=%0d -> counter=%0d valid=%0d err=%0d",
             data, nbits, counter, n_valid - v0, n_err - e0);
  endtask

  initial begin
    logic        ev;
    logic [13:0] ec;
    logic [31:0] rdata;
    int          rbits, sel, v0, e0;

    vecs[0] = '{32'h1234,  16, 1'b1, 14'h1234};
    vecs[1] = '{32'h270F,  16, 1'b1, 14'd9999};
    vecs[2] = '{32'h0005,   8, 1'b0, 14'd9999};
    vecs[3] = '{32'h2710,  16, !RANGE_EN, RANGE_EN ? 14'd9999 : 14'd10000};
    vecs[4] = '{32'h22223, 17, 1'b0, RANGE_EN ? 14'd9999 : 14'd10000};
    vecs[5] = '{32'h000A,   4, 1'b0, RANGE_EN ? 14'd9999 : 14'd10000};
    vecs[6] = '{32'h0000,  16, 1'b1, 14'd0};
    vecs[7] = '{32'hC003,  16, !RANGE_EN, RANGE_EN ? 14'd0 : 14'd3};
    vecs[8] = '{32'h1234,  16, 1'b1, 14'h1234};

    reset = 1'b1;
    sclk  = 1'b0;
    mosi  = 1'b0;
    ss_n  = 1'b1;
    clk_wait(3);
    check("reset_counter", 32'(counter), 32'd0);
    check("reset_valid", 32'(counter_valid), 32'd0);
    check("reset_err", 32'(frame_err), 32'd0);
    reset = 1'b0;
    clk_wait(10);

    for (int i = 0; i < 9; i++) begin
      run_frame(vecs[i].data, vecs[i].nbits, vecs[i].exp_valid, vecs[i].exp_counter);
      model_counter = vecs[i].exp_counter;
    end

    // Reset after 10 bits, released while ss_n is still low.
    v0 = n_valid;
    e0 = n_err;
    ss_n = 1'b0;
    clk_wait(HALF);
    send_bits(32'h2AB, 10);
    reset = 1'b1;
    clk_wait(2);
    check("midreset_counter", 32'(counter), 32'd0);
    check("midreset_valid", 32'(counter_valid), 32'd0);
    check("midreset_err", 32'(frame_err), 32'd0);
    clk_wait(1);
    reset = 1'b0;
    send_bits(32'h15, 6);
    clk_wait(HALF);
    ss_n = 1'b1;
    clk_wait(SYNC + 10);
    check("postreset_counter", 32'(counter), 32'd0);
    check("postreset_pulses", 32'((n_valid - v0) + (n_err - e0)), 32'd0);
    $display("reset mid-frame -> counter=%0d pulses=%0d", counter, (n_valid - v0) + (n_err - e0));
    model_counter = 14'd0;
    run_frame(32'h002A, 16, 1'b1, 14'd42);
    model_counter = 14'd42;

    for (int i = 0; i < 20; i++) begin
      sel = $urandom_range(0, 9);
      rdata = $urandom;
      if (sel == 0) rbits = 8;
      else if (sel == 1) rbits = 17;
      else if (sel == 2) rbits = $urandom_range(1, 15);
      else rbits = 16;
      if ($urandom_range(0, 1) == 1) rdata[15:8] = 8'($urandom_range(0, 8'h27));
      rdata = rdata & ((rbits == 17) ? 32'h1FFFF : 32'hFFFF);
      model_frame(rdata, rbits, ev, ec);
      run_frame(rdata, rbits, ev, ec);
      model_counter = ec;
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/spi_counter_rx.md
SPI_COUNTER_RX -- requirements
Module: spi_counter_rx

Interface
REQ-001 The module SHALL have parameter SYNC_STAGES, default 2, giving the synchronizer depth for sclk, mosi and ss_n.
REQ-002 The module SHALL have port clk, input, 1 bit: system clock; all state updates on its rising edge.
REQ-003 The module SHALL have port reset, input, 1 bit: reset, asynchronous, active-high.
REQ-004 The module SHALL have port sclk, input, 1 bit: SPI serial clock, asynchronous to clk, idle low (mode 0).
REQ-005 The module SHALL have port mosi, input, 1 bit: SPI data, MSB first.
REQ-006 The module SHALL have port ss_n, input, 1 bit: SPI slave select, active-low; low for the whole 16-bit frame.
REQ-007 The module SHALL have port counter, output, 14 bits: last accepted counter value.
REQ-008 The module SHALL have port counter_valid, output, 1 bit: one-clk pulse when counter updates.
REQ-009 The module SHALL have port frame_err, output, 1 bit: one-clk pulse when a frame is discarded.

Function
REQ-010 The module SHALL pass sclk, mosi and ss_n through SYNC_STAGES flip-flops and detect sclk/ss_n edges on the synchronized signals.
REQ-011 The module SHALL sample synchronized mosi on each synchronized sclk rising edge while synchronized ss_n is low, shifting MSB first.
REQ-012 The module SHALL support sclk high and low phases each of at least 4 clk periods; behaviour at faster sclk is not required.
REQ-013 The module SHALL implement FSM states IDLE, RX_HIGH, RX_LOW, WAIT_END, UPDATE.
REQ-014 The module SHALL go IDLE -> RX_HIGH on ss_n falling edge and clear its bit counter and shift register.
REQ-015 The module SHALL go RX_HIGH -> RX_LOW after 8 bits, latching the high byte.
REQ-016 The module SHALL go RX_LOW -> WAIT_END after 8 further bits, latching the low byte.
REQ-017 The module SHALL go WAIT_END -> UPDATE on ss_n rising edge; any sclk rising edge in WAIT_END marks the frame overlong.
REQ-018 The module SHALL, in UPDATE, set counter = {high[5:0], low[7:0]} and pulse counter_valid for one clk, then return to IDLE.
REQ-019 The module SHALL make counter valid within 2 clk of the synchronized ss_n rising edge.
REQ-020 The module SHALL, on ss_n rising in RX_HIGH or RX_LOW (short frame), pulse frame_err, leave counter unchanged and return to IDLE.
REQ-021 The module SHALL, for an overlong frame, pulse frame_err instead of updating counter.
REQ-022 The module SHALL never assert counter_valid and frame_err in the same cycle.
REQ-023 The module SHALL ignore sclk and mosi activity while ss_n is high.
REQ-024 The module SHALL hold counter between frames; consecutive frames need at least 4 clk of ss_n high between them.

Reset
REQ-025 The module SHALL, during reset, force state IDLE, counter = 0, counter_valid = 0, frame_err = 0, shift register and bit count = 0, and synchronizers to ss_n = 1, sclk = 0.
REQ-026 The module SHALL, after reset released mid-frame (ss_n already low), stay IDLE until a new ss_n falling edge, with no pulse on either output.

Configuration
REQ-027 The module SHALL, with macro SPI_COUNTER_RX_RANGE_CHECK_EN defined, reject frames with high[7:6] != 0 or value > 9999 by pulsing frame_err and keeping counter unchanged.
REQ-028 The module SHALL, without SPI_COUNTER_RX_RANGE_CHECK_EN, ignore high[7:6] and accept any 14-bit value.

Structure
REQ-029 The shared package spi_counter_pkg SHALL hold the state_t enum, FRAME_BITS = 16, BYTE_BITS = 8 and COUNT_MAX = 9999.
REQ-030 The design SHALL contain one sub-module, spi_slave_rx_byte: synchronizer, edge detect, 8-bit shifter and byte_done pulse. Framing and range logic SHALL reside in spi_counter_rx.

Verification
REQ-031 The bench SHALL send bytes 0x12, 0x34 in one frame and require counter = 0x1234 (4660), one counter_valid pulse, no frame_err.
REQ-032 The bench SHALL send bytes 0x27, 0x0F and require counter = 9999 with a counter_valid pulse.
REQ-033 The bench SHALL raise ss_n after 8 bits (0x05) and require a frame_err pulse and counter to keep its prior value.
REQ-034 The bench SHALL send bytes 0x27, 0x10 (10000) and require a frame_err pulse with the macro and counter = 10000 with a counter_valid pulse without it.
REQ-035 The bench SHALL send 17 bits, then raise ss_n, and require frame_err with counter unchanged.
REQ-036 The bench SHALL assert reset after 10 bits, release it with ss_n low, finish the frame, and require no output pulses, then a clean frame 0x00, 0x2A giving counter = 42.
